axis_q15_requant: RTL
=====================

Name: axis_q15_requant

Overview:
- AXI-Stream sink placed at the output of the 15-tap FIR filter. It consumes the filter's 32-bit signed Q30 products/sums and returns them to the 16-bit Q15 sample domain.
- Each sample is rounded, shifted and saturated, then buffered in a small FIFO. The buffered samples are re-emitted as a 16-bit AXI-Stream with tlast preserved.
- Frame length and tkeep are checked, and saturation events are counted, for software/ILA visibility.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- FRAME_LEN, 64, expected beats per frame (tlast on beat FRAME_LEN-1, counting from 0).
- SHIFT, 15, right-shift applied to the 32-bit input; range 1..16.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  32  signed input sample.
- s_axis_tkeep  in  4  byte enables; 4'hF expected.
- s_axis_tlast  in  1  end of input frame.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  16  signed Q15 output sample.
- m_axis_tlast  out  1  end of output frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- frame_err  out  1  sticky: tlast position did not match FRAME_LEN.
- keep_err  out  1  sticky: an accepted beat had tkeep != 4'hF.
- sat_count  out  16  number of saturated samples (see Optional Feature).

Behaviour:
- Reset (async assert, synchronous-release use):
  - FIFO emptied; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=0 while reset is asserted, 1 on the first cycle after release.
  - frame_err=0, keep_err=0, sat_count=0; frame FSM returns to IDLE.
  - A reset in mid-frame discards all buffered beats and the partial frame; no error is flagged.
- Accept and emit:
  - Input is accepted when s_axis_tvalid && s_axis_tready.
  - Output is consumed when m_axis_tvalid && m_axis_tready.
- Ready and valid:
  - s_axis_tready is registered and equals (count < DEPTH) after the current cycle's push/pop.
  - When full, a simultaneous pop raises tready on the next cycle.
  - m_axis_tvalid = FIFO not empty. m_axis_tdata and m_axis_tlast present the head entry.
  - Head data stays stable while valid && !ready (AXI rule).
- Latency: a sample accepted in cycle N is valid on m_axis in cycle N+1 when the FIFO was empty. Full throughput is 1 beat/clk when m_axis_tready=1.
- Simultaneous push and pop:
  - When not empty and not full, both occur and count is unchanged.
  - When empty, a pop cannot occur, so only the push takes effect.
- Arithmetic, done combinationally at push time; each stored entry is 17 bits (data + last):
  - Sign-extend tdata to 33 bits.
  - Add 1<<(SHIFT-1) (round half up).
  - Arithmetic shift right by SHIFT.
  - Clamp to [-32768, 32767].
  - A clamp event is "sat".
- tkeep is not used as a data mask. An accepted beat with tkeep != 4'hF sets keep_err; the beat is still processed.
- Frame FSM, two states, advancing only on accepted beats; beat_cnt is $clog2(FRAME_LEN) bits wide:
  - IDLE: on accept with tlast=1 → stay IDLE; frame_err is set unless FRAME_LEN==1. On accept with tlast=0 → IN_FRAME, beat_cnt=1.
  - IN_FRAME, accept with tlast=1: frame_err is set if beat_cnt != FRAME_LEN-1; then → IDLE, beat_cnt=0.
  - IN_FRAME, accept with tlast=0: frame_err is set if beat_cnt == FRAME_LEN-1 (missing tlast); then beat_cnt=0 and stay IN_FRAME. Otherwise beat_cnt increments.
- tlast is passed through unchanged; it is never regenerated.
- frame_err and keep_err clear only on reset.

Optional Feature:
- Macro: AXIS_REQUANT_SAT_COUNT_EN.
- Defined: sat_count increments on each accepted saturated beat and holds at 16'hFFFF (no wrap).
- Undefined: the counter logic is removed and sat_count is tied to 16'd0. Saturation behaviour itself is unchanged.

Decomposition:
- Package axis_requant_pkg holds:
  - Q15_MAX = 16'sh7FFF and Q15_MIN = 16'sh8000.
  - IN_W = 32, OUT_W = 16.
  - The frame-state enum {ST_IDLE, ST_IN_FRAME}.
- Sub-module axis_sync_fifo (WIDTH, DEPTH): single-clock, async active-low reset, full/empty/count outputs, first-word-fall-through head. Top level holds the requant datapath, the FSM, the flags and the counter.

Test Plan:
- Rounding: SHIFT=15, m_axis_tready=1; send 32'h0000_4000, then 32'h0000_3FFF → m_axis_tdata=16'h0001, then 16'h0000, each one cycle after accept; sat_count=0.
- Saturation: send 32'h4000_0000, 32'h8000_0000, 32'hC000_0000 → outputs 16'h7FFF, 16'h8000, 16'h8000; sat_count=2 (macro defined) or 0 (undefined).
- Backpressure: DEPTH=8, m_axis_tready=0, drive 10 consecutive valid beats → exactly 8 accepted; s_axis_tready=0 from the cycle after the 8th accept. Then raise tready → all 8 emitted in order, one per clk, and input resumes.
- Frame check: FRAME_LEN=4.
  - tlast on beat 3 → frame_err stays 0.
  - Next frame, tlast on beat 2 → frame_err=1 and stays 1.
  - m_axis_tlast appears on the same samples as the input tlast.
- keep_err: one beat with tkeep=4'h3 → keep_err=1 and the beat is still output correctly.
- Reset mid-operation: 5 beats buffered, assert reset for 1 cycle → m_axis_tvalid=0 immediately and flags/counters are 0. After release, the new beat 32'h0000_8000 emits 16'h0001 and starts a fresh frame.

Source files
------------

// File: rtl/axis_requant_pkg.sv
// Shared constants and frame-state type for the Q30 -> Q15 requantiser.
package axis_requant_pkg;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;

    localparam logic signed [OUT_W-1:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [OUT_W-1:0] Q15_MIN = 16'sh8000;

    typedef enum logic {
        ST_IDLE,
        ST_IN_FRAME
    } frame_state_e;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head; the head reads zero when empty.
module axis_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/axis_q15_requant.sv
// AXI-Stream Q30 -> Q15 round/shift/saturate stage with frame and tkeep checks.
// Define AXIS_REQUANT_SAT_COUNT_EN to build the saturation event counter.
//
// state       | meaning
// ST_IDLE     | between frames, next accepted beat is beat 0
// ST_IN_FRAME | inside a frame, beat_q holds the index of the next beat
module axis_q15_requant
    import axis_requant_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 64,
    parameter int SHIFT     = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN_W-1:0]    s_axis_tdata,
    input  logic [3:0]         s_axis_tkeep,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [OUT_W-1:0]   m_axis_tdata,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               frame_err,
    output logic               keep_err,
    output logic [15:0]        sat_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

    localparam logic signed [IN_W:0] RND    = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] LIM_HI = 33'sd32767;
    localparam logic signed [IN_W:0] LIM_LO = -33'sd32768;

    logic                 tready_q;
    logic                 frame_err_q;
    logic                 keep_err_q;
    frame_state_e         state_q;
    logic [BW-1:0]        beat_q;

    logic                 acc;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        cnt_next;
    logic [OUT_W:0]       fifo_dout;

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shf;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_W-1:0]     q15;

    assign acc = s_axis_tvalid && tready_q && !fifo_full;
    assign pop = !fifo_empty && m_axis_tready;

    // 33-bit intermediate cannot overflow when the rounding constant is added.
    always_comb begin
        ext    = {s_axis_tdata[IN_W-1], s_axis_tdata};
        rnd    = ext + RND;
        shf    = rnd >>> SHIFT;
        sat_hi = (shf > LIM_HI);
        sat_lo = (shf < LIM_LO);
        if (sat_hi)      q15 = Q15_MAX;
        else if (sat_lo) q15 = Q15_MIN;
        else             q15 = shf[OUT_W-1:0];
    end

    axis_sync_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (acc),
        .din   ({s_axis_tlast, q15}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cnt_next = fifo_count + {{(CW-1){1'b0}}, acc} - {{(CW-1){1'b0}}, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tready_q <= 1'b0;
        else        tready_q <= (cnt_next < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            frame_err_q <= 1'b0;
        end else if (acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tlast) begin
                        if (FRAME_LEN != 1) frame_err_q <= 1'b1;
                    end else begin
                        state_q <= ST_IN_FRAME;
                        beat_q  <= BW'(1);
                    end
                end
                ST_IN_FRAME: begin
                    if (s_axis_tlast) begin
                        if (beat_q != LAST_BEAT) frame_err_q <= 1'b1;
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                    end else if (beat_q == LAST_BEAT) begin
                        frame_err_q <= 1'b1;
                        beat_q      <= '0;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           keep_err_q <= 1'b0;
        else if (acc && s_axis_tkeep != 4'hF) keep_err_q <= 1'b1;
    end

`ifdef AXIS_REQUANT_SAT_COUNT_EN
    logic        sat;
    logic [15:0] sat_cnt_q;

    assign sat = sat_hi || sat_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 sat_cnt_q <= '0;
        else if (acc && sat && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 16'd0;
`endif

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_dout[OUT_W-1:0];
    assign m_axis_tlast  = fifo_dout[OUT_W];
    assign frame_err     = frame_err_q;
    assign keep_err      = keep_err_q;

endmodule
